// File: rtl/mem_arbiter_pkg.sv
// Shared constants, FSM state and requester encodings for the memory arbiter.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package mem_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 128;
    localparam int MEM_AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_IF = 3'd1,
        DONE_IF  = 3'd2,
        ISSUE_D  = 3'd3,
        DONE_D   = 3'd4
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(DEPTH);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port signals of the arbiter, bundled.
// Latency: none (wiring only).
// Backpressure: req held until ack; the arbiter is the only memory master.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_arb_prio.sv
// Fixed load/store-first priority select with a saturating fetch-starvation override.
// Latency: grant is combinational; the starve counter updates on the granting edge.
// Backpressure: the loser is not latched; it simply keeps requesting.
module arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    if_req,
    input  logic    d_req,
    input  logic    grant_take,
    output req_id_t grant_id,
    output logic    grant_valid
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        grant_valid = if_req | d_req;
        grant_id    = (d_req && !(if_req && starved)) ? REQ_D : REQ_IF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_take) begin
            if (grant_id == REQ_IF) begin
                starve_cnt <= '0;
            end else if (if_req && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store requests onto one synchronous memory port.
// Latency: req seen in IDLE -> mem strobe next cycle -> ack pulse 3 cycles after req.
// Backpressure: requesters hold req until ack; the unserved side simply waits.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    state_t            state;
    req_id_t           grant_id;
    logic              grant_valid;
    logic              arb_ok;
    logic              oor_q;
    logic              we_q;
    logic [ADDR_W-1:0] gaddr;
    logic              gstore;

    // The IDLE cycle carrying an ack must not arbitrate: the acked requester's
    // req is still the old, already-served transaction at that point.
    assign arb_ok = (state == IDLE) && !bus.if_ack && !bus.d_ack;

    arb_prio #(.STARVE_MAX(STARVE_MAX)) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req      (bus.if_req & arb_ok),
        .d_req       (bus.d_req & arb_ok),
        .grant_take  (grant_valid),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always_comb begin
        gaddr  = (grant_id == REQ_D) ? bus.d_addr : bus.if_addr;
        gstore = (grant_id == REQ_D) && bus.d_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            oor_q         <= 1'b0;
            we_q          <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_ack    <= 1'b0;
            bus.if_err    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_ack     <= 1'b0;
            bus.d_err     <= 1'b0;
            bus.d_rdata   <= '0;
        end else begin
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            bus.if_ack <= 1'b0;
            bus.if_err <= 1'b0;
            bus.d_ack  <= 1'b0;
            bus.d_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        oor_q <= !in_range(gaddr);
                        we_q  <= gstore;
                        if (in_range(gaddr)) begin
                            bus.mem_en   <= 1'b1;
                            bus.mem_we   <= gstore;
                            bus.mem_addr <= gaddr[MEM_AW-1:0];
                            if (gstore) begin
                                bus.mem_wdata <= bus.d_wdata;
                            end
                        end
                        state <= (grant_id == REQ_D) ? ISSUE_D : ISSUE_IF;
                    end
                end
                ISSUE_IF: state <= DONE_IF;
                ISSUE_D:  state <= DONE_D;
                DONE_IF: begin
                    bus.if_ack   <= 1'b1;
                    bus.if_err   <= oor_q;
                    bus.if_rdata <= oor_q ? '0 : bus.mem_rdata;
                    state        <= IDLE;
                end
                DONE_D: begin
                    bus.d_ack <= 1'b1;
                    bus.d_err <= oor_q;
                    if (!we_q) begin
                        bus.d_rdata <= oor_q ? '0 : bus.mem_rdata;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
